ex_mem_stage: RTL

EX→MEM pipeline stage of the MIPS datapath, directly downstream of the ALU.
- Captures alu_result, zero_bit, store data, destination register and MEM/WB control bits each accepted cycle.
- Resolves the branch decision from zero_bit.
- Decouples EX from MEM with a valid/ready handshake and a 2-entry skid buffer, so MEM back-pressure never forces a combinational in_ready path.

---
 rtl/ex_mem_pkg.sv | 23 ++
 rtl/ex_mem_entry.sv | 26 ++
 rtl/ex_mem_stage.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/ex_mem_pkg.sv
// Shared types and constants for the EX->MEM pipeline stage.
// The optional bne resolution is enabled by defining EX_MEM_BNE_EN.
package ex_mem_pkg;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } state_e;

    localparam int unsigned CTRL_REG_WRITE  = 3;
    localparam int unsigned CTRL_MEM_TO_REG = 2;
    localparam int unsigned CTRL_MEM_READ   = 1;
    localparam int unsigned CTRL_MEM_WRITE  = 0;

    localparam int unsigned CTRL_W = 4;

    // Packed entry layout: {alu_result, rt_data, dest_reg, ctrl}
    function automatic int unsigned entry_width(int unsigned data_w, int unsigned reg_w);
        return 2 * data_w + reg_w + CTRL_W;
    endfunction

endpackage

// File: rtl/ex_mem_entry.sv
// One packed pipeline entry: load-enable register with synchronous clear.
module ex_mem_entry
    import ex_mem_pkg::*;
#(
    parameter int unsigned Width = 73
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [Width-1:0] data_i,
    output logic [Width-1:0] data_o
);

    logic [Width-1:0] data_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= data_i;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM stage with a 2-entry skid buffer and branch resolution from zero_bit.
// Define EX_MEM_BNE_EN to add the branch_ne input and resolve bne as well as beq.
module ex_mem_stage
    import ex_mem_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              zero_bit,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [REG_W-1:0]  dest_reg,
    input  logic [3:0]        ctrl,
    input  logic              branch,
`ifdef EX_MEM_BNE_EN
    input  logic              branch_ne,
`endif
    input  logic [DATA_W-1:0] branch_target,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_alu_result,
    output logic [DATA_W-1:0] out_wdata,
    output logic [REG_W-1:0]  out_dest_reg,
    output logic [3:0]        out_ctrl,
    output logic              pc_src,
    output logic [DATA_W-1:0] pc_target
);

    localparam int unsigned EntryW = entry_width(DATA_W, REG_W);

    state_e state_q, state_d;

    logic              accept;
    logic              pop;
    logic              taken_cond;
    logic              main_load;
    logic              skid_load;
    logic [EntryW-1:0] in_entry;
    logic [EntryW-1:0] main_d;
    logic [EntryW-1:0] main_q;
    logic [EntryW-1:0] skid_q;

    logic              pc_src_d, pc_src_q;
    logic [DATA_W-1:0] pc_target_d, pc_target_q;

    // in_ready depends only on registered state, never on out_ready
    assign in_ready  = (state_q != StTwo);
    assign out_valid = (state_q != StEmpty);

    assign accept   = in_valid & in_ready;
    assign pop      = out_valid & out_ready;
    assign in_entry = {alu_result, rt_data, dest_reg, ctrl};

`ifdef EX_MEM_BNE_EN
    // beq wins when both branch flags are set
    assign taken_cond = branch ? zero_bit : (branch_ne & ~zero_bit);
`else
    assign taken_cond = branch & zero_bit;
`endif

    always_comb begin
        state_d   = state_q;
        main_load = 1'b0;
        skid_load = 1'b0;
        main_d    = in_entry;

        if (flush) begin
            state_d = StEmpty;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (accept) begin
                        main_load = 1'b1;
                        state_d   = StOne;
                    end
                end
                StOne: begin
                    if (accept && pop) begin
                        main_load = 1'b1;
                    end else if (accept) begin
                        skid_load = 1'b1;
                        state_d   = StTwo;
                    end else if (pop) begin
                        state_d = StEmpty;
                    end
                end
                StTwo: begin
                    if (pop) begin
                        main_load = 1'b1;
                        main_d    = skid_q;
                        state_d   = StOne;
                    end
                end
                default: begin
                    state_d = StEmpty;
                end
            endcase
        end
    end

    always_comb begin
        pc_src_d    = accept & taken_cond & ~flush;
        pc_target_d = pc_target_q;
        if (pc_src_d) begin
            pc_target_d = branch_target;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= StEmpty;
            pc_src_q    <= 1'b0;
            pc_target_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_src_q    <= pc_src_d;
            pc_target_q <= pc_target_d;
        end
    end

    ex_mem_entry #(
        .Width (EntryW)
    ) u_main (
        .clk_i  (Clk),
        .rst_i  (Reset),
        .load_i (main_load),
        .data_i (main_d),
        .data_o (main_q)
    );

    ex_mem_entry #(
        .Width (EntryW)
    ) u_skid (
        .clk_i  (Clk),
        .rst_i  (Reset),
        .load_i (skid_load),
        .data_i (in_entry),
        .data_o (skid_q)
    );

    assign {out_alu_result, out_wdata, out_dest_reg, out_ctrl} = main_q;

    assign pc_src    = pc_src_q;
    assign pc_target = pc_target_q;

endmodule
